frame_deframer_commit_fifo: RTL and testbench

- Sits directly downstream of the fault-tolerant bit aligner and consumes its aligned 32-bit word stream: data, valid, and soft-lock status.
- Hunts frame headers, parses sequence number and length, and buffers payload speculatively in an internal FIFO.
- Commits a frame to the output only when its checksum passes; otherwise rolls back.
- Delivers committed frames on a valid/ready stream with tlast, plus saturating error/statistics counters.

---
 rtl/frame_deframer_commit_fifo.sv | 175 +++++++++++++++++
 tb/tb_frame_deframer_commit_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_deframer_commit_fifo.sv
// Frame deframer for the aligned 32-bit word stream: hunts headers, buffers payload
// speculatively, commits on a good checksum and streams committed frames out with tlast.
module frame_deframer_commit_fifo #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned MAX_LEN     = 256,
   parameter logic [31:0] HDR_WORD    = 32'hEB94_BDA3,
   parameter logic [31:0] IDLE_WORD   = 32'h0707_0707,
   parameter int unsigned GAP_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_data,
   input  logic        i_valid,
   input  logic        i_locked,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic [15:0] o_seq,
   output logic [15:0] o_good_cnt,
   output logic [15:0] o_chk_err_cnt,
   output logic [15:0] o_len_err_cnt,
   output logic [15:0] o_ovf_cnt,
   output logic [15:0] o_abort_cnt,
   output logic [15:0] o_seq_gap_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned GW = $clog2(GAP_TIMEOUT + 1);

   typedef enum logic [1:0] {S_HUNT, S_INFO, S_PAY, S_CHK} state_t;

   state_t        state, state_nxt;
   logic [32:0]   mem [DEPTH];
   logic [PW-1:0] wr_spec, wr_commit, wr_commit_q, rd;
   logic [PW-1:0] used;
   logic [31:0]   free_words;
   logic [15:0]   info_len, len_rem, seq_r, exp_seq;
   logic [31:0]   xor_acc;
   logic [GW-1:0] gap_cnt;
   logic          seq_ref_ok;
   logic          abort, gap_hit, hdr_hit, len_bad, no_room, pay_last;
   logic          len_err_ev, ovf_ev, admit, pay_wr, chk_pass, chk_fail;
   logic          rd_load;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HUNT;
      else        state <= state_nxt;
   end

   always_comb begin
      used       = wr_commit - rd;
      free_words = 32'(DEPTH) - 32'(used);
      info_len   = i_data[15:0];
      gap_hit    = !i_valid && (gap_cnt == GW'(GAP_TIMEOUT - 1));
      abort      = (state != S_HUNT) && (!i_locked || gap_hit);
      // filler can never open a frame, even if the two patterns are configured alike
      hdr_hit    = i_valid && i_locked && (i_data == HDR_WORD) && (i_data != IDLE_WORD);
      len_bad    = (info_len == '0) || (32'(info_len) > MAX_LEN);
      no_room    = 32'(info_len) > free_words;
      pay_last   = (len_rem == 16'd1);
      state_nxt  = state;
      len_err_ev = 1'b0;
      ovf_ev     = 1'b0;
      admit      = 1'b0;
      pay_wr     = 1'b0;
      chk_pass   = 1'b0;
      chk_fail   = 1'b0;
      if (abort) begin
         state_nxt = S_HUNT;
      end else begin
         case (state)
            S_HUNT: if (hdr_hit) state_nxt = S_INFO;
            S_INFO: if (i_valid) begin
               state_nxt = S_HUNT;
               if (len_bad)      len_err_ev = 1'b1;
               else if (no_room) ovf_ev     = 1'b1;
               else begin
                  admit     = 1'b1;
                  state_nxt = S_PAY;
               end
            end
            S_PAY: if (i_valid) begin
               pay_wr = 1'b1;
               if (pay_last) state_nxt = S_CHK;
            end
            S_CHK: if (i_valid) begin
               chk_pass  = (i_data == xor_acc);
               chk_fail  = (i_data != xor_acc);
               state_nxt = S_HUNT;
            end
            default: state_nxt = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_spec       <= '0;
         wr_commit     <= '0;
         wr_commit_q   <= '0;
         seq_r         <= '0;
         len_rem       <= '0;
         xor_acc       <= '0;
         gap_cnt       <= '0;
         seq_ref_ok    <= 1'b0;
         exp_seq       <= '0;
         o_seq         <= '0;
         o_good_cnt    <= '0;
         o_chk_err_cnt <= '0;
         o_len_err_cnt <= '0;
         o_ovf_cnt     <= '0;
         o_abort_cnt   <= '0;
         o_seq_gap_cnt <= '0;
      end else begin
         // read side sees a commit one cycle late, giving a two-cycle commit-to-output latency
         wr_commit_q <= wr_commit;
         if (state == S_HUNT || i_valid || abort) gap_cnt <= '0;
         else                                     gap_cnt <= gap_cnt + 1'b1;
         if (admit) begin
            seq_r   <= i_data[31:16];
            len_rem <= info_len;
            xor_acc <= i_data;
         end
         if (pay_wr) begin
            xor_acc <= xor_acc ^ i_data;
            wr_spec <= wr_spec + 1'b1;
            len_rem <= len_rem - 16'd1;
         end
         if (chk_fail || abort) wr_spec <= wr_commit;
         if (chk_pass) begin
            wr_commit  <= wr_spec;
            o_good_cnt <= sat_inc(o_good_cnt);
            o_seq      <= seq_r;
            exp_seq    <= seq_r + 16'd1;
            seq_ref_ok <= 1'b1;
            if (seq_ref_ok && (seq_r != exp_seq)) o_seq_gap_cnt <= sat_inc(o_seq_gap_cnt);
         end
         if (chk_fail)   o_chk_err_cnt <= sat_inc(o_chk_err_cnt);
         if (len_err_ev) o_len_err_cnt <= sat_inc(o_len_err_cnt);
         if (ovf_ev)     o_ovf_cnt     <= sat_inc(o_ovf_cnt);
         if (abort) begin
            o_abort_cnt <= sat_inc(o_abort_cnt);
            seq_ref_ok  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pay_wr) mem[wr_spec[AW-1:0]] <= {pay_last, i_data};
   end

   assign rd_load = (rd != wr_commit_q) && (!m_tvalid || m_tready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd       <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (rd_load) begin
         {m_tlast, m_tdata} <= mem[rd[AW-1:0]];
         m_tvalid           <= 1'b1;
         rd                 <= rd + 1'b1;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_frame_deframer_commit_fifo.sv
// Scoreboard bench: frame-level reference model predicts delivered words and counters;
// a negedge monitor checks every presented output word against the expectation queue.
module tb_frame_deframer_commit_fifo;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned MAX_LEN = 12;
   localparam int unsigned GAP     = 8;
   localparam logic [31:0] HDR     = 32'hEB94_BDA3;
   localparam logic [31:0] IDLE    = 32'h0707_0707;
   localparam int K_GOOD = 0, K_BADCHK = 1, K_LENERR = 2, K_OVF = 3, K_LOCK = 4, K_GAP = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_data;
   logic        i_valid, i_locked;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [15:0] o_seq, o_good_cnt, o_chk_err_cnt, o_len_err_cnt;
   logic [15:0] o_ovf_cnt, o_abort_cnt, o_seq_gap_cnt;

   always #5 clk = ~clk;

   frame_deframer_commit_fifo #(
      .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .HDR_WORD(HDR), .IDLE_WORD(IDLE), .GAP_TIMEOUT(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_locked(i_locked),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .o_seq(o_seq), .o_good_cnt(o_good_cnt), .o_chk_err_cnt(o_chk_err_cnt),
      .o_len_err_cnt(o_len_err_cnt), .o_ovf_cnt(o_ovf_cnt), .o_abort_cnt(o_abort_cnt),
      .o_seq_gap_cnt(o_seq_gap_cnt)
   );

   typedef struct packed { logic [31:0] data; logic last; } word_t;

   word_t       exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          ready_mode = 1;   // 0 stall, 1 always ready, 2 random
   logic        gaps_en = 1'b0;
   int          mg, mc, ml, mo, ma, msg;
   logic [15:0] m_seq, m_exp;
   logic        m_ref;

   task automatic model_reset();
      mg = 0; mc = 0; ml = 0; mo = 0; ma = 0; msg = 0;
      m_seq = '0; m_exp = '0; m_ref = 1'b0;
      exp_q.delete();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && m_tvalid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL out_unexpected: data=%08h last=%0b, required no word", m_tdata, m_tlast);
            end else begin
               w = exp_q[0];
               if (m_tdata !== w.data || m_tlast !== w.last) begin
                  n_err++;
                  $display("FAIL %s: data=%08h last=%0b, required data=%08h last=%0b",
                           m_tready ? "out_word" : "stall_hold", m_tdata, m_tlast, w.data, w.last);
               end
               if (m_tready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic v, input logic l, input logic [31:0] d);
      i_valid = v; i_locked = l; i_data = d;
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [31:0] d);
      if (gaps_en && $urandom_range(0, 7) == 0)
         repeat ($urandom_range(1, 3)) drive(1'b0, 1'b1, IDLE);
      drive(1'b1, 1'b1, d);
   endtask

   // pmode: 0 random payload, 1 ramp 0x11,0x22,..., 2 random with a header pattern at word 1.
   // cut: payload words sent before an abort; negative aborts before the info word.
   task automatic send_frame(input logic [15:0] seq, input logic [15:0] len, input int kind,
                             input int cut, input int pmode, input int long_gap_at);
      logic [31:0] info, x, p;
      word_t       pl[$];
      int          n;
      logic        is_abort;
      is_abort = (kind == K_LOCK) || (kind == K_GAP);
      info = {seq, len};
      x = info;
      send_word(HDR);
      if (!(is_abort && cut < 0)) send_word(info);
      if (kind == K_LENERR) ml++;
      else if (kind == K_OVF) mo++;
      else begin
         n = is_abort ? ((cut < 0) ? 0 : cut) : int'(len);
         for (int i = 0; i < n; i++) begin
            p = (pmode == 1) ? 32'h11 * 32'(i + 1) : ((pmode == 2 && i == 1) ? HDR : $urandom);
            if (i == long_gap_at) repeat (GAP - 1) drive(1'b0, 1'b1, IDLE);
            x ^= p;
            pl.push_back('{data: p, last: (i == int'(len) - 1)});
            send_word(p);
         end
         case (kind)
            K_GOOD: begin
               foreach (pl[i]) exp_q.push_back(pl[i]);
               mg++;
               if (m_ref && seq != m_exp) msg++;
               m_exp = seq + 16'd1; m_ref = 1'b1; m_seq = seq;
               send_word(x);
            end
            K_BADCHK: begin
               mc++;
               send_word(x ^ 32'd1);
            end
            K_LOCK: begin
               ma++; m_ref = 1'b0;
               drive(1'b1, 1'b0, $urandom);
               drive(1'b0, 1'b0, IDLE);
            end
            default: begin
               ma++; m_ref = 1'b0;
               repeat (GAP) drive(1'b0, 1'b1, IDLE);
            end
         endcase
      end
      i_valid = 1'b0; i_locked = 1'b1; i_data = IDLE;
   endtask

   task automatic wait_space(input int len);
      int t = 0;
      while (exp_q.size() + len > DEPTH && t < 2000) begin
         @(posedge clk); #1; t++;
      end
      if (exp_q.size() + len > DEPTH) begin
         n_checks++; n_err++;
         $display("FAIL space_wait: queued=%0d, required <= %0d", exp_q.size(), DEPTH - len);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk); #1; t++;
      end
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input logic idle_req);
      @(negedge clk);
      check("o_seq",         32'(o_seq),         32'(m_seq));
      check("o_good_cnt",    32'(o_good_cnt),    32'(mg));
      check("o_chk_err_cnt", 32'(o_chk_err_cnt), 32'(mc));
      check("o_len_err_cnt", 32'(o_len_err_cnt), 32'(ml));
      check("o_ovf_cnt",     32'(o_ovf_cnt),     32'(mo));
      check("o_abort_cnt",   32'(o_abort_cnt),   32'(ma));
      check("o_seq_gap_cnt", 32'(o_seq_gap_cnt), 32'(msg));
      if (idle_req) check("tvalid_idle", 32'(m_tvalid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
      $fatal(1);
   end

   initial begin
      logic [15:0] seq, len;
      int          kind, r, cut;
      logic [31:0] noise;
      rst_n = 1'b0; i_valid = 1'b0; i_locked = 1'b1; i_data = IDLE;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tlast",  32'(m_tlast),  32'd0);
      check("rst_tdata",  m_tdata,       32'd0);
      @(posedge clk); #1;
      check_counters(1'b1);

      // good frame with commit-to-valid latency
      ready_mode = 1;
      repeat (3) drive(1'b1, 1'b1, IDLE);
      send_frame(16'd5, 16'd4, K_GOOD, 0, 1, -1);
      @(negedge clk); check("latency_e0", 32'(m_tvalid), 32'd0);
      @(negedge clk); check("latency_e1", 32'(m_tvalid), 32'd0);
      @(negedge clk); check("latency_e2", 32'(m_tvalid), 32'd1);
      @(posedge clk); #1;
      wait_drain();
      check_counters(1'b1);

      // bad checksum followed by good frame carrying a header pattern in payload
      send_frame(16'd6, 16'd4, K_BADCHK, 0, 1, -1);
      send_frame(16'd6, 16'd5, K_GOOD, 0, 2, -1);
      wait_drain();
      check_counters(1'b1);

      // length errors, then overflow with the output stalled
      send_frame(16'd9, 16'd0, K_LENERR, 0, 0, -1);
      send_frame(16'd9, 16'(MAX_LEN + 1), K_LENERR, 0, 0, -1);
      ready_mode = 0;
      repeat (2) drive(1'b0, 1'b1, IDLE);
      send_frame(16'd7, 16'd10, K_GOOD, 0, 0, -1);
      send_frame(16'd8, 16'd10, K_OVF, 0, 0, -1);
      repeat (4) drive(1'b0, 1'b1, IDLE);
      check_counters(1'b0);
      ready_mode = 1;
      wait_drain();
      check_counters(1'b1);

      // aborts by lock loss and gap timeout, then clean frames incl. a just-tolerated gap
      send_frame(16'd8, 16'd4, K_LOCK, 2, 0, -1);
      send_frame(16'd8, 16'd4, K_GAP, 2, 0, -1);
      send_frame(16'd8, 16'd4, K_GAP, -1, 0, -1);
      send_frame(16'd50, 16'd4, K_GOOD, 0, 0, -1);
      send_frame(16'd51, 16'd4, K_GOOD, 0, 0, 2);
      wait_drain();
      check_counters(1'b1);

      // sequence gap under random backpressure, lengths 1..MAX_LEN
      send_frame(16'd0, 16'd4, K_LOCK, 0, 0, -1);
      ready_mode = 2;
      wait_space(5);       send_frame(16'd7, 16'd5, K_GOOD, 0, 0, -1);
      wait_space(MAX_LEN); send_frame(16'd8, 16'(MAX_LEN), K_GOOD, 0, 0, -1);
      wait_space(1);       send_frame(16'd10, 16'd1, K_GOOD, 0, 0, -1);
      wait_drain();
      check_counters(1'b1);

      // reset mid-frame discards committed and speculative data
      ready_mode = 0;
      send_frame(16'd60, 16'd3, K_GOOD, 0, 0, -1);
      send_word(HDR); send_word({16'd61, 16'd5}); send_word($urandom); send_word($urandom);
      rst_n = 1'b0;
      model_reset();
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ready_mode = 1;
      repeat (6) drive(1'b0, 1'b1, IDLE);
      check_counters(1'b1);
      send_frame(16'd1, 16'd3, K_GOOD, 0, 0, -1);
      wait_drain();
      check_counters(1'b1);

      // randomized frames
      gaps_en = 1'b1;
      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         r = int'($urandom_range(0, 99));
         kind = (r < 55) ? K_GOOD : (r < 70) ? K_BADCHK : (r < 80) ? K_LENERR : (r < 90) ? K_LOCK : K_GAP;
         len = 16'($urandom_range(1, MAX_LEN));
         if (kind == K_LENERR) len = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAX_LEN + 1, 300));
         seq = ($urandom_range(0, 4) == 0) ? 16'($urandom) : m_exp;
         cut = int'($urandom_range(0, int'(len) + 1)) - 1;
         if (kind != K_LENERR) wait_space(int'(len));
         repeat ($urandom_range(0, 3)) begin
            noise = $urandom;
            if (noise == HDR) noise = IDLE;
            drive(1'b1, 1'b1, noise);
         end
         send_frame(seq, len, kind, cut, 0, -1);
      end
      wait_drain();
      check_counters(1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
